// File: rtl/spn_pkg.sv
// spn_pkg: shared constants, types and layer functions for the PRESENT-style SPN core
package spn_pkg;
  localparam int BLOCKW = 64;
  localparam int KEYW = 80;
  localparam int NIBW = 4;
  typedef logic [BLOCKW-1:0] block_t;
  typedef logic [KEYW-1:0] key_t;
  // Forward S-box, entry x at bits [4x+3:4x]; the decrypt side cross-checks its inverse against this
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;
  // Bit j moves to (16*j) mod 63; bit 63 stays in place
  function automatic block_t spn_player(block_t b);
    block_t p;
    p = '0;
    for (int j = 0; j < 63; j++) p[(16 * j) % 63] = b[j];
    p[63] = b[63];
    return p;
  endfunction
  // Rotate left by 61 and inject the round counter; the caller substitutes the top nibble
  // (bits [79:76] and [19:15] are disjoint, so the order of these two steps is immaterial)
  function automatic key_t spn_keyupd(key_t k, logic [4:0] rnd);
    key_t r;
    r = {k[18:0], k[79:19]};
    r[19:15] = r[19:15] ^ rnd;
    return r;
  endfunction
endpackage

// File: rtl/spn_sbox4.sv
// spn_sbox4: forward 4-bit S-box lookup, purely combinational
module spn_sbox4
  import spn_pkg::*;
(
  input  logic [NIBW-1:0] din,
  output logic [NIBW-1:0] dout
);
  assign dout = SBOX_TABLE[{din, 2'b00} +: NIBW];
endmodule

// File: rtl/spn_encrypt_core.sv
// spn_encrypt_core: iterative one-round-per-clock 64-bit SPN encryption engine with valid/ready
module spn_encrypt_core #(
  parameter int BLOCKW = 64,
  parameter int KEYW = 80,
  parameter int ROUNDS = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLOCKW-1:0] in_data,
  input  logic [KEYW-1:0]   in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLOCKW-1:0] out_data
);
  import spn_pkg::*;
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_rounds_chk
    $error("ROUNDS must be in 1..31");
  end
  if (BLOCKW != spn_pkg::BLOCKW || KEYW != spn_pkg::KEYW) begin : g_width_chk
    $error("BLOCKW/KEYW are fixed by the permutation and key schedule");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t fsm;
  block_t state, sub_in, sub_out;
  key_t key, key_rot, key_nxt;
  logic [4:0] rnd;
  logic [3:0] key_nib;
  // Round-key XOR doubles as the final whitening once the FSM reaches DONE
  assign sub_in = state ^ key[79:16];
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    spn_sbox4 u_sbox (.din(sub_in[4*i +: 4]), .dout(sub_out[4*i +: 4]));
  end
  assign key_rot = spn_keyupd(key, rnd);
  spn_sbox4 u_key_sbox (.din(key_rot[79:76]), .dout(key_nib));
  assign key_nxt = {key_nib, key_rot[75:0]};
  assign out_data = out_valid ? sub_in : '0;
  // Control FSM with registered handshake outputs, plus state/key/round datapath
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= IDLE;
      state <= '0;
      key <= '0;
      rnd <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state <= in_data;
          key <= in_key;
          rnd <= 5'd1;
          fsm <= RUN;
          in_ready <= 1'b0;
        end
        RUN: begin
          state <= spn_player(sub_out);
          key <= key_nxt;
          rnd <= rnd + 5'd1;
          if (rnd == ROUNDS[4:0]) begin
            fsm <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          fsm <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: fsm <= IDLE;
      endcase
    end
endmodule
